snn_spike_readout: RTL and testbench

//  Consumes the per-timestep spike vector of the LIF core and accumulates per-neuron spike counts over a frame of T_STEPS steps.
//  At frame end, sequentially scans the counts and returns the winning class (argmax) through a valid/ready result port.

---
 rtl/snn_pkg.sv | 15 +
 rtl/snn_spike_readout_if.sv | 32 +++
 rtl/snn_argmax_scan.sv | 35 +++
 rtl/snn_spike_readout.sv | 104 ++++++++++
 tb/tb_snn_spike_readout.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types and width helpers for the SNN readout path.
package snn_pkg;

  typedef enum logic [1:0] {RO_IDLE, RO_ACCUM, RO_SCAN, RO_HOLD} readout_state_t;

  // Width of a counter that has to hold the values 0..t_steps.
  function automatic int cw_of(input int t_steps);
    return $clog2(t_steps + 1);
  endfunction

  function automatic int iw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snn_spike_readout_if.sv
// Spike-in / class-out port bundle between the LIF core, the readout and its consumer.
interface snn_spike_readout_if import snn_pkg::*; #(
  parameter int N       = 96,
  parameter int T_STEPS = 100
);
  localparam int CW = cw_of(T_STEPS);
  localparam int IW = iw_of(N);

  logic          start;
  logic          step_valid;
  logic [N-1:0]  spikes_vec;
  logic          busy;
  logic          start_err;
  logic          result_valid;
  logic          result_ready;
  logic [IW-1:0] result_class;
  logic [CW-1:0] result_count;
  logic          result_tie;
  logic          result_silent;

  modport master (
    output start, step_valid, spikes_vec, result_ready,
    input  busy, start_err, result_valid, result_class, result_count,
           result_tie, result_silent
  );

  modport slave (
    input  start, step_valid, spikes_vec, result_ready,
    output busy, start_err, result_valid, result_class, result_count,
           result_tie, result_silent
  );
endinterface

// File: rtl/snn_argmax_scan.sv
// Sequential argmax: fed one (index, count) pair per cycle, keeps the running
// winner (lowest index on equal counts) and whether the winning count is shared.
module snn_argmax_scan #(
  parameter int IW = 7,
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scan_en,
  input  logic          scan_first,
  input  logic [IW-1:0] idx,
  input  logic [CW-1:0] cnt,
  output logic [IW-1:0] best_idx,
  output logic [CW-1:0] best_cnt,
  output logic          best_tie
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_idx <= '0;
      best_cnt <= '0;
      best_tie <= 1'b0;
    end else if (scan_en) begin
      // The first element seeds the winner, so no sentinel value is needed.
      if (scan_first || (cnt > best_cnt)) begin
        best_idx <= idx;
        best_cnt <= cnt;
        best_tie <= 1'b0;
      end else if (cnt == best_cnt) begin
        best_tie <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/snn_spike_readout.sv
// Frame-level spike counter and argmax classifier sitting behind the LIF core.
module snn_spike_readout import snn_pkg::*; #(
  parameter int N       = 96,
  parameter int T_STEPS = 100
) (
  input logic                clk,
  input logic                rst,
  snn_spike_readout_if.slave bus
);

  localparam int            CW        = cw_of(T_STEPS);
  localparam int            IW        = iw_of(N);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] STEP_LAST = CW'(T_STEPS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  readout_state_t state_q, state_d;
  logic [CW-1:0]  step_cnt_q;
  logic [IW-1:0]  scan_idx_q;
  logic [CW-1:0]  cnt_q [N];
  logic           frame_start, step_take, scan_en, hold;
  logic [IW-1:0]  best_idx;
  logic [CW-1:0]  best_cnt;
  logic           best_tie;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RO_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    step_take   = 1'b0;
    scan_en     = 1'b0;
    unique case (state_q)
      RO_IDLE: begin
        if (bus.start) begin
          frame_start = 1'b1;
          state_d     = RO_ACCUM;
        end
      end
      RO_ACCUM: begin
        step_take = bus.step_valid;
        if (step_take && (step_cnt_q == STEP_LAST)) state_d = RO_SCAN;
      end
      RO_SCAN: begin
        scan_en = 1'b1;
        if (scan_idx_q == IDX_LAST) state_d = RO_HOLD;
      end
      RO_HOLD: begin
        if (bus.result_ready) state_d = RO_IDLE;
      end
      default: state_d = RO_IDLE;
    endcase
  end

  // NOTE: the count array is reset too, so no stale frame survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else if (frame_start) begin
      step_cnt_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else if (step_take) begin
      step_cnt_q <= step_cnt_q + 1'b1;
      for (int i = 0; i < N; i++) begin
        if (bus.spikes_vec[i] && (cnt_q[i] != CNT_MAX)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              scan_idx_q <= '0;
    else if (frame_start) scan_idx_q <= '0;
    else if (scan_en)     scan_idx_q <= (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
  end

  snn_argmax_scan #(.IW(IW), .CW(CW)) u_scan (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (scan_en),
    .scan_first (scan_idx_q == '0),
    .idx        (scan_idx_q),
    .cnt        (cnt_q[scan_idx_q]),
    .best_idx   (best_idx),
    .best_cnt   (best_cnt),
    .best_tie   (best_tie)
  );

  // Result fields are only exposed while a result is pending.
  assign hold              = (state_q == RO_HOLD);
  assign bus.busy          = (state_q == RO_ACCUM) || (state_q == RO_SCAN);
  assign bus.start_err     = bus.start && (state_q != RO_IDLE);
  assign bus.result_valid  = hold;
  assign bus.result_class  = hold ? best_idx : '0;
  assign bus.result_count  = hold ? best_cnt : '0;
  assign bus.result_tie    = hold && best_tie;
  assign bus.result_silent = hold && (best_cnt == '0);

endmodule

// File: tb/tb_snn_spike_readout.sv
// Randomised frame-level bench for snn_spike_readout against a plain argmax model.
module tb_snn_spike_readout;
  import snn_pkg::*;

  localparam int N  = 96;
  localparam int T  = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snn_spike_readout_if #(.N(N), .T_STEPS(T)) bus ();

  snn_spike_readout #(.N(N), .T_STEPS(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mc [N];
  int exp_class, exp_count;
  bit exp_tie, exp_silent;
  int prob [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rand_vec();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    foreach (mc[i]) mc[i] = 0;
  endtask

  task automatic feed(input logic [N-1:0] v);
    bus.step_valid = 1'b1;
    bus.spikes_vec = v;
    tick();
    bus.step_valid = 1'b0;
    bus.spikes_vec = rand_vec();
    for (int i = 0; i < N; i++) if (v[i]) mc[i]++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.spikes_vec = rand_vec();
      tick();
    end
  endtask

  // Argmax straight from the frame's spike totals.
  task automatic model_argmax();
    int mx, n_max;
    mx = -1;
    n_max = 0;
    for (int i = 0; i < N; i++) if (mc[i] > mx) begin mx = mc[i]; exp_class = i; end
    for (int i = 0; i < N; i++) if (mc[i] == mx) n_max++;
    exp_count  = mx;
    exp_tie    = (n_max > 1);
    exp_silent = (mx == 0);
  endtask

  task automatic wait_result(input int already);
    int cyc = already;
    while (!bus.result_valid && cyc < N + 10) begin
      tick();
      cyc++;
    end
    check("latency", cyc, N);
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_valid"},  bus.result_valid, 1);
    check({tag, "_class"},  bus.result_class, exp_class);
    check({tag, "_count"},  bus.result_count, exp_count);
    check({tag, "_tie"},    bus.result_tie, exp_tie);
    check({tag, "_silent"}, bus.result_silent, exp_silent);
  endtask

  task automatic accept();
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("valid_drop", bus.result_valid, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   bus.busy, 0);
    check({tag, "_valid"},  bus.result_valid, 0);
    check({tag, "_err"},    bus.start_err, 0);
    check({tag, "_class"},  bus.result_class, 0);
    check({tag, "_count"},  bus.result_count, 0);
    check({tag, "_tie"},    bus.result_tie, 0);
    check({tag, "_silent"}, bus.result_silent, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] v;
    int mode;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.step_valid = 1'b0;
    bus.spikes_vec = '0;
    bus.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;
    tick();

    // Reset mid-accumulation, then an all-zero frame.
    begin_frame();
    check("accum_busy", bus.busy, 1);
    repeat (10) feed(rand_vec());
    rst = 1'b1;
    #1;
    check_quiet("mid_reset");
    tick();
    rst = 1'b0;
    repeat (5) feed(rand_vec());
    check("idle_ignores_steps", bus.busy, 0);
    begin_frame();
    repeat (T) feed('0);
    wait_result(0);
    model_argmax();
    check_fields("silent");
    accept();

    // Single active neuron.
    begin_frame();
    v = '0;
    v[7] = 1'b1;
    repeat (T) feed(v);
    wait_result(0);
    model_argmax();
    check_fields("n7");
    accept();

    // Two leaders at 50 spikes each, everyone else capped at 30.
    begin_frame();
    for (int s = 0; s < T; s++) begin
      v = '0;
      if (s >= 50 && s < 80) begin
        v = rand_vec();
        v[3] = 1'b0;
        v[40] = 1'b0;
      end
      if (s < 50) begin
        v[3] = 1'b1;
        v[40] = 1'b1;
      end
      feed(v);
    end
    wait_result(0);
    model_argmax();
    check("tie_model_class", exp_class, 3);
    check_fields("tie");
    accept();

    // Valid only every third cycle; the frame must wait for the 100th step.
    begin_frame();
    for (int s = 0; s < T; s++) begin
      idle(2);
      if (s == T - 1) begin
        idle(N + 10);
        check("gap_no_early_valid", bus.result_valid, 0);
        check("gap_still_busy", bus.busy, 1);
      end
      feed(rand_vec());
    end
    wait_result(0);
    model_argmax();
    check_fields("gaps");
    accept();

    // start during SCAN and HOLD, long back-pressure, start with handshake.
    begin_frame();
    repeat (T) feed(rand_vec());
    model_argmax();
    bus.start = 1'b1;
    #1;
    check("err_scan", bus.start_err, 1);
    tick();
    bus.start = 1'b0;
    #1;
    check("err_scan_clr", bus.start_err, 0);
    wait_result(1);
    check_fields("after_scan_start");
    bus.start = 1'b1;
    #1;
    check("err_hold", bus.start_err, 1);
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check_fields("hold_stable");
      tick();
    end
    bus.start = 1'b1;
    bus.result_ready = 1'b1;
    #1;
    check("err_handshake", bus.start_err, 1);
    tick();
    bus.start = 1'b0;
    bus.result_ready = 1'b0;
    check("hs_valid_drop", bus.result_valid, 0);
    check("hs_start_ignored", bus.busy, 0);
    tick();
    check("hs_still_idle", bus.busy, 0);

    // Random frames with varied densities and gaps.
    for (int f = 0; f < 200; f++) begin
      mode = $urandom_range(0, 3);
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: prob[i] = $urandom_range(0, 255);
          1: prob[i] = $urandom_range(0, 4);
          2: prob[i] = 0;
          default: prob[i] = ($urandom_range(0, 15) == 0) ? 128 : 0;
        endcase
      end
      begin_frame();
      for (int s = 0; s < T; s++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 255) < prob[i]);
        bus.result_ready = 1'($urandom);
        feed(v);
      end
      bus.result_ready = 1'b0;
      wait_result(0);
      model_argmax();
      check_fields("rand");
      accept();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
